// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the halfband MAC phase sequencer.
package mac_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  // A one-tap filter still needs a 1-bit select.
  function automatic int sel_width(input int num_taps);
    return (num_taps <= 2) ? 1 : $clog2(num_taps);
  endfunction

  localparam int COEF_T0     = -174;
  localparam int COEF_T1     = 1637;
  localparam int COEF_T2     = -7962;
  localparam int COEF_T3     = 39267;
  localparam int COEF_CENTER = 65536;

endpackage

// File: rtl/mac_seq_if.sv
// Sequencer <-> enable-generator / MAC datapath signal bundle.
// Coefficient config signals exist only with MAC_SEQ_COEFF_RAM_EN defined.
interface mac_seq_if #(
  parameter int SEL_W = 2
`ifdef MAC_SEQ_COEFF_RAM_EN
 ,parameter int COEFF_W = 18
`endif
);

  logic             sample_valid;
  logic             in_ready;
  logic [SEL_W-1:0] tap_sel;
  logic             tap_valid;
  logic             center_en;
  logic             acc_load;
  logic             acc_en;
  logic             y_load;
  logic             busy;
  logic             overrun;
  logic             overrun_clr;
`ifdef MAC_SEQ_COEFF_RAM_EN
  logic               cfg_we;
  logic [SEL_W-1:0]   cfg_addr;
  logic [COEFF_W-1:0] cfg_data;
  logic [COEFF_W-1:0] coeff;
  logic               cfg_err;

  modport master (
    output sample_valid, overrun_clr, cfg_we, cfg_addr, cfg_data,
    input  in_ready, tap_sel, tap_valid, center_en, acc_load, acc_en,
           y_load, busy, overrun, coeff, cfg_err
  );
  modport slave (
    input  sample_valid, overrun_clr, cfg_we, cfg_addr, cfg_data,
    output in_ready, tap_sel, tap_valid, center_en, acc_load, acc_en,
           y_load, busy, overrun, coeff, cfg_err
  );
`else
  modport master (
    output sample_valid, overrun_clr,
    input  in_ready, tap_sel, tap_valid, center_en, acc_load, acc_en,
           y_load, busy, overrun
  );
  modport slave (
    input  sample_valid, overrun_clr,
    output in_ready, tap_sel, tap_valid, center_en, acc_load, acc_en,
           y_load, busy, overrun
  );
`endif

endinterface

// File: rtl/mac_tag_pipe.sv
// DEPTH-stage {valid, first, last} delay line matched to the MAC datapath.
// Shifts every clock; o_any_valid flags any product still in flight.
module mac_tag_pipe
  import mac_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  tag_t i_tag,
  output tag_t o_tag,
  output logic o_any_valid
);

  tag_t r_stage [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

  always_comb begin
    o_any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) o_any_valid = o_any_valid | r_stage[i].valid;
  end

endmodule

// File: rtl/mac_phase_sequencer.sv
// Issues one tap select per clock per sample strobe and drives accumulator/output strobes
// through a tag pipe matched to the datapath. Optional coefficient RAM: MAC_SEQ_COEFF_RAM_EN.
module mac_phase_sequencer
  import mac_seq_pkg::*;
#(
  parameter int NUM_TAPS   = 4,
  parameter int PIPE_DELAY = 4,
  parameter int SEL_W      = sel_width(NUM_TAPS)
`ifdef MAC_SEQ_COEFF_RAM_EN
 ,parameter int COEFF_W    = 18
`endif
) (
  input  logic      clk,
  input  logic      reset_n,
  mac_seq_if.slave  bus
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_TAPS - 1);

  state_t           r_state;
  logic [SEL_W-1:0] r_cnt;
  logic             r_center_en;
  logic             r_in_ready;
  logic             r_overrun;
  logic             r_y_load;

  logic             w_accept;
  logic             w_last;
  logic [SEL_W-1:0] w_cnt_inc;
  logic             w_busy;
  logic             w_tags_live;
  tag_t             w_tag_in;
  tag_t             w_tag_out;

  assign w_accept  = bus.sample_valid & r_in_ready;
  assign w_last    = (r_cnt == LAST_SEL);
  assign w_cnt_inc = r_cnt + SEL_W'(1);

  // in_ready/center_en are precomputed for the cycle the counter will hold next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_center_en <= 1'b0;
      r_in_ready  <= 1'b1;
      r_overrun   <= 1'b0;
      r_y_load    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_state     <= ISSUE;
        r_cnt       <= '0;
        r_center_en <= (LAST_SEL == '0);
        r_in_ready  <= (LAST_SEL == '0);
      end else if (r_state == ISSUE && !w_last) begin
        r_cnt       <= w_cnt_inc;
        r_center_en <= (w_cnt_inc == LAST_SEL);
        r_in_ready  <= (w_cnt_inc == LAST_SEL);
      end else begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_center_en <= 1'b0;
        r_in_ready  <= 1'b1;
      end

      if (bus.sample_valid && !r_in_ready) r_overrun <= 1'b1;
      else if (bus.overrun_clr)            r_overrun <= 1'b0;

      r_y_load <= w_tag_out.valid & w_tag_out.last;
    end
  end

  assign w_tag_in.valid = (r_state == ISSUE);
  assign w_tag_in.first = (r_cnt == '0);
  assign w_tag_in.last  = w_last;

  mac_tag_pipe #(
    .DEPTH (PIPE_DELAY)
  ) u_tag_pipe (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_tag       (w_tag_in),
    .o_tag       (w_tag_out),
    .o_any_valid (w_tags_live)
  );

  assign w_busy = (r_state != IDLE) | w_tags_live | r_y_load;

  assign bus.in_ready  = r_in_ready;
  assign bus.tap_sel   = r_cnt;
  assign bus.tap_valid = (r_state == ISSUE);
  assign bus.center_en = r_center_en;
  assign bus.acc_load  = w_tag_out.valid & w_tag_out.first;
  assign bus.acc_en    = w_tag_out.valid & ~w_tag_out.first;
  assign bus.y_load    = r_y_load;
  assign bus.busy      = w_busy;
  assign bus.overrun   = r_overrun;

`ifdef MAC_SEQ_COEFF_RAM_EN
  logic [COEFF_W-1:0] r_coef [NUM_TAPS];
  logic               r_cfg_err;
  logic               w_cfg_bad;

  // Coefficients may only change between samples so a product never mixes old and new sets.
  assign w_cfg_bad = bus.cfg_we & (w_busy | (int'(bus.cfg_addr) >= NUM_TAPS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TAPS; i++) r_coef[i] <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      if (bus.cfg_we && !w_cfg_bad) r_coef[bus.cfg_addr] <= bus.cfg_data;
      if (w_cfg_bad)                r_cfg_err <= 1'b1;
      else if (bus.overrun_clr)     r_cfg_err <= 1'b0;
    end
  end

  assign bus.coeff   = r_coef[r_cnt];
  assign bus.cfg_err = r_cfg_err;
`endif

endmodule

// File: tb/tb_mac_phase_sequencer.sv
// Bench for mac_phase_sequencer: default instance (4 taps, delay 4) plus a 1-tap/1-delay instance.
`timescale 1ns/1ps
module tb_mac_phase_sequencer;
  import mac_seq_pkg::*;

  localparam int N0 = 4, PD0 = 4, SW0 = 2, LAT0 = N0 + PD0 + 1;
  localparam int N1 = 1, PD1 = 1, SW1 = 1, LAT1 = N1 + PD1 + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int q0[$];
  int q1[$];
  int exp0_c, exp1_c;

`ifdef MAC_SEQ_COEFF_RAM_EN
  mac_seq_if #(.SEL_W(SW0), .COEFF_W(18)) bus0();
  mac_seq_if #(.SEL_W(SW1), .COEFF_W(18)) bus1();
  mac_phase_sequencer #(.NUM_TAPS(N0), .PIPE_DELAY(PD0), .SEL_W(SW0), .COEFF_W(18))
    dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  mac_phase_sequencer #(.NUM_TAPS(N1), .PIPE_DELAY(PD1), .SEL_W(SW1), .COEFF_W(18))
    dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
`else
  mac_seq_if #(.SEL_W(SW0)) bus0();
  mac_seq_if #(.SEL_W(SW1)) bus1();
  mac_phase_sequencer #(.NUM_TAPS(N0), .PIPE_DELAY(PD0), .SEL_W(SW0))
    dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  mac_phase_sequencer #(.NUM_TAPS(N1), .PIPE_DELAY(PD1), .SEL_W(SW1))
    dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
`endif

  // {tap_sel (0 when idle), tap_valid, center_en, acc_load, acc_en, busy, in_ready}
  logic [7:0] act0;
  assign act0 = {(bus0.tap_valid ? bus0.tap_sel : 2'b00), bus0.tap_valid, bus0.center_en,
                 bus0.acc_load, bus0.acc_en, bus0.busy, bus0.in_ready};
  // {tap_valid, center_en, acc_load, acc_en, busy, in_ready}
  logic [5:0] act1;
  assign act1 = {bus1.tap_valid, bus1.center_en, bus1.acc_load, bus1.acc_en,
                 bus1.busy, bus1.in_ready};

  // Reference timeline for the default instance given up to two accepted strobes (-1 = none).
  function automatic logic [7:0] exp_ctrl(input int c, input int s0, input int s1);
    logic [1:0] sel;
    logic tv, ce, al, ae, bz, ir;
    int starts[2];
    int k;
    sel = 2'b00; tv = 0; ce = 0; al = 0; ae = 0; bz = 0; ir = 1;
    starts[0] = s0;
    starts[1] = s1;
    for (int j = 0; j < 2; j++) begin
      if (starts[j] >= 0) begin
        k = c - starts[j] - 1;
        if (k >= 0 && k < N0) begin
          tv = 1; sel = 2'(k); ce = (k == N0 - 1);
          if (k < N0 - 1) ir = 0;
        end
        if (k == PD0) al = 1;
        if (k > PD0 && k < PD0 + N0) ae = 1;
        if (k >= 0 && k <= N0 + PD0) bz = 1;
      end
    end
    return {sel, tv, ce, al, ae, bz, ir};
  endfunction

  // Scoreboard: every y_load pulse must match the next predicted cycle.
  always @(negedge clk) begin
    if (bus0.y_load !== 1'b0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL y_load0_unexpected cycle=%0d got=%b required=0", cyc, bus0.y_load);
      end else begin
        exp0_c = q0.pop_front();
        if (cyc !== exp0_c) begin
          errors++;
          $display("FAIL y_load0_timing got_cycle=%0d required_cycle=%0d", cyc, exp0_c);
        end
      end
    end
    if (bus1.y_load !== 1'b0) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL y_load1_unexpected cycle=%0d got=%b required=0", cyc, bus1.y_load);
      end else begin
        exp1_c = q1.pop_front();
        if (cyc !== exp1_c) begin
          errors++;
          $display("FAIL y_load1_timing got_cycle=%0d required_cycle=%0d", cyc, exp1_c);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (act0 !== 8'b0000_0001) begin
      errors++; $display("FAIL reset_ctrl0 got=%b required=%b", act0, 8'b0000_0001);
    end
    checks++;
    if (act1 !== 6'b00_0001) begin
      errors++; $display("FAIL reset_ctrl1 got=%b required=%b", act1, 6'b00_0001);
    end
    checks++;
    if ({bus0.overrun, bus0.y_load, bus1.overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b required=000",
                         {bus0.overrun, bus0.y_load, bus1.overrun});
    end
`ifdef MAC_SEQ_COEFF_RAM_EN
    checks++;
    if ({bus0.coeff, bus0.cfg_err} !== 19'd0) begin
      errors++; $display("FAIL reset_coeff got=%0d/%b required=0/0", bus0.coeff, bus0.cfg_err);
    end
`endif
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (act0 !== 8'b0000_0001) begin
      errors++; $display("FAIL post_reset_ctrl0 got=%b required=%b", act0, 8'b0000_0001);
    end
  endtask

  task automatic test_single();
    logic [7:0] e;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      e = exp_ctrl(c, 0, -1);
      checks++;
      if (act0 !== e) begin
        errors++; $display("FAIL single c=%0d got=%b required=%b", c, act0, e);
      end
      bus0.sample_valid = (c == 0);
      if (c == 0) q0.push_back(cyc + LAT0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      e = exp_ctrl(c, 0, 4);
      checks++;
      if (act0 !== e) begin
        errors++; $display("FAIL back_to_back c=%0d got=%b required=%b", c, act0, e);
      end
      bus0.sample_valid = (c == 0 || c == 4);
      if (c == 0 || c == 4) q0.push_back(cyc + LAT0);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] e;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      e = exp_ctrl(c, 0, -1);
      checks++;
      if (act0 !== e) begin
        errors++; $display("FAIL overrun_ctrl c=%0d got=%b required=%b", c, act0, e);
      end
      checks++;
      if (bus0.overrun !== (c >= 3)) begin
        errors++; $display("FAIL overrun_flag c=%0d got=%b required=%b", c, bus0.overrun, (c >= 3));
      end
      bus0.sample_valid = (c == 0 || c == 2);
      if (c == 0) q0.push_back(cyc + LAT0);
    end
    bus0.overrun_clr = 1'b1;
    @(negedge clk);
    bus0.overrun_clr = 1'b0;
    checks++;
    if (bus0.overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_clear got=%b required=0", bus0.overrun);
    end
    // Clear and a fresh overrun in the same cycle: the new overrun must stick.
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c == 3) begin
        checks++;
        if (bus0.overrun !== 1'b1) begin
          errors++; $display("FAIL overrun_set_wins got=%b required=1", bus0.overrun);
        end
      end
      bus0.sample_valid = (c == 0 || c == 2);
      bus0.overrun_clr  = (c == 2);
      if (c == 0) q0.push_back(cyc + LAT0);
    end
    bus0.overrun_clr = 1'b1;
    @(negedge clk);
    bus0.overrun_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      e = exp_ctrl(c, 0, -1);
      checks++;
      if (act0 !== e) begin
        errors++; $display("FAIL reset_mid_pre c=%0d got=%b required=%b", c, act0, e);
      end
      bus0.sample_valid = (c == 0);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({act0, bus0.y_load, bus0.overrun} !== 10'b0000_0001_00) begin
      errors++; $display("FAIL reset_mid_async got=%b required=%b",
                         {act0, bus0.y_load, bus0.overrun}, 10'b0000_0001_00);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (act0 !== 8'b0000_0001) begin
        errors++; $display("FAIL reset_mid_after c=%0d got=%b required=%b", c, act0, 8'b0000_0001);
      end
    end
  endtask

`ifdef MAC_SEQ_COEFF_RAM_EN
  task automatic test_coeff_ram();
    logic [17:0] t0;
    t0 = 18'(COEF_T0);
    @(negedge clk);
    bus0.cfg_we = 1'b1; bus0.cfg_addr = 2'd3; bus0.cfg_data = 18'(COEF_T3);
    @(negedge clk);
    bus0.cfg_addr = 2'd0; bus0.cfg_data = t0;
    @(negedge clk);
    bus0.cfg_we = 1'b0;
    checks++;
    if (bus0.cfg_err !== 1'b0) begin
      errors++; $display("FAIL cfg_idle_err got=%b required=0", bus0.cfg_err);
    end
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c <= 12; c++) begin
        @(negedge clk);
        if (c == 1) begin
          checks++;
          if (bus0.coeff !== t0) begin
            errors++; $display("FAIL coeff_tap0 s=%0d got=%0d required=%0d", s, bus0.coeff, t0);
          end
        end
        if (c == 4) begin
          checks++;
          if ({bus0.tap_sel, bus0.coeff} !== {2'd3, 18'd39267}) begin
            errors++; $display("FAIL coeff_tap3 s=%0d got=%0d/%0d required=3/39267",
                               s, bus0.tap_sel, bus0.coeff);
          end
        end
        if (c == 3 && s == 0) begin
          checks++;
          if (bus0.cfg_err !== 1'b1) begin
            errors++; $display("FAIL cfg_busy_err got=%b required=1", bus0.cfg_err);
          end
        end
        bus0.sample_valid = (c == 0);
        if (c == 0) q0.push_back(cyc + LAT0);
        bus0.cfg_we   = (c == 2 && s == 0);
        bus0.cfg_addr = 2'd0;
        bus0.cfg_data = 18'd5;
      end
    end
    bus0.overrun_clr = 1'b1;
    @(negedge clk);
    bus0.overrun_clr = 1'b0;
    checks++;
    if (bus0.cfg_err !== 1'b0) begin
      errors++; $display("FAIL cfg_err_clear got=%b required=0", bus0.cfg_err);
    end
  endtask
`endif

  task automatic test_single_tap();
    logic [5:0] e;
    logic tv, al, bz;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      tv = (c >= 1 && c <= 8);
      al = (c >= 2 && c <= 9);
      bz = (c >= 1 && c <= 10);
      e  = {tv, tv, al, 1'b0, bz, 1'b1};
      checks++;
      if (act1 !== e) begin
        errors++; $display("FAIL single_tap c=%0d got=%b required=%b", c, act1, e);
      end
      bus1.sample_valid = (c <= 7);
      if (c <= 7) q1.push_back(cyc + LAT1);
    end
  endtask

  initial begin
    bus0.sample_valid = 1'b0; bus0.overrun_clr = 1'b0;
    bus1.sample_valid = 1'b0; bus1.overrun_clr = 1'b0;
`ifdef MAC_SEQ_COEFF_RAM_EN
    bus0.cfg_we = 1'b0; bus0.cfg_addr = '0; bus0.cfg_data = '0;
    bus1.cfg_we = 1'b0; bus1.cfg_addr = '0; bus1.cfg_data = '0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
`ifdef MAC_SEQ_COEFF_RAM_EN
    test_coeff_ram();
`endif
    test_single_tap();
    repeat (6) @(negedge clk);
    checks++;
    if (q0.size() != 0) begin
      errors++; $display("FAIL y_load0_missing got_pending=%0d required=0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++; $display("FAIL y_load1_missing got_pending=%0d required=0", q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_phase_sequencer.md
Name: mac_phase_sequencer

Overview:
- Control block for the time-shared halfband MAC datapath: one multiplier, one accumulator, several symmetric tap pairs per output sample.
- Accepts one sample strobe per output period and issues tap-select/phase codes to the multiplier muxes, one per clock.
- Carries first/last tags down a delay line matched to the datapath pipeline, then drives accumulator load/accumulate and output-register capture.
- Sits between the sample-rate enable generator and the MAC datapath.

Parameters:
- NUM_TAPS, 4, multiplier passes per sample (unique symmetric tap pairs, center excluded).
- PIPE_DELAY, 4, clocks from tap_sel issue to product at accumulator input (mux + mult + sum register + delay line); minimum 1.
- SEL_W, 2, width of tap_sel; must satisfy 2**SEL_W >= NUM_TAPS.
- COEFF_W, 18, coefficient width (used only with COEFF_RAM_EN).

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  one-cycle strobe: new sample present in the tap delay line.
- in_ready  out  1  sequencer can accept sample_valid this cycle.
- tap_sel  out  SEL_W  tap-pair/coefficient select for the multiplier muxes.
- tap_valid  out  1  tap_sel is a live issue this cycle.
- center_en  out  1  add center tap this cycle (aligned with tap_sel).
- acc_load  out  1  accumulator loads the product (first tap of a sample).
- acc_en  out  1  accumulator adds the product (non-first taps).
- y_load  out  1  output register captures the accumulator.
- busy  out  1  any tap issued or in flight.
- overrun  out  1  sticky: sample_valid seen while in_ready was low.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset values (asynchronous): all outputs 0, except in_ready=1. Tag pipe cleared; state IDLE; tap counter 0.
- FSM states:
  - IDLE: tap_valid=0, in_ready=1. On sample_valid, go to ISSUE with counter=0.
  - ISSUE: tap_valid=1, tap_sel=counter, counter increments each cycle. in_ready=1 only when counter==NUM_TAPS-1.
    - On the last tap: sample_valid restarts ISSUE with counter=0 (back-to-back, no bubble); otherwise go to IDLE.
- Issue timing:
  - sample_valid accepted at edge t; tap k is issued in cycle t+1+k.
  - center_en=1 only with tap_sel==NUM_TAPS-1.
- Tag pipe: PIPE_DELAY stages of {valid, first, last}, written at issue, shifted every clk.
  - At the pipe output: acc_load = valid & first; acc_en = valid & !first.
  - y_load is a one-cycle pulse in the cycle after the last-tagged product reaches the accumulator.
  - Latency from sample_valid edge to y_load = NUM_TAPS + PIPE_DELAY + 1 clocks.
- busy = (state != IDLE) | any tag valid | y_load pending.
- Overrun:
  - sample_valid with in_ready=0 is dropped; overrun is set the next edge.
  - If overrun_clr and a new overrun occur in the same cycle, set wins.
- NUM_TAPS==1: every ISSUE cycle is both first and last, so acc_load with no acc_en; in_ready stays 1 throughout.
- reset_n asserted mid-operation: in-flight tags are discarded and no y_load is produced for a partial sample.

Optional Feature:
- Macro: MAC_SEQ_COEFF_RAM_EN.
- When defined, adds ports cfg_we (in 1), cfg_addr (in SEL_W), cfg_data (in COEFF_W), coeff (out COEFF_W), cfg_err (out 1, sticky, cleared by overrun_clr).
  - Holds an internal NUM_TAPS-entry coefficient register file; all entries reset to 0.
  - coeff is the registered value at tap_sel, aligned with tap_sel.
  - cfg_we is honoured only when busy=0. A write while busy is ignored and sets cfg_err.
  - cfg_addr >= NUM_TAPS is ignored and sets cfg_err.
- When not defined: no cfg ports; coefficients come from an external ROM indexed by tap_sel.

Decomposition:
- Shared package mac_seq_pkg holds:
  - state enum (IDLE, ISSUE);
  - tag struct {valid, first, last};
  - function computing SEL_W from NUM_TAPS;
  - default coefficient constants (-174, 1637, -7962, 39267, center 65536).
- Natural sub-module: mac_tag_pipe, a parameterised PIPE_DELAY-deep tag shift register with asynchronous reset.

Test Plan:
- Single sample, defaults: sample_valid at cycle 0 -> tap_sel 0,1,2,3 in cycles 1-4; center_en in cycle 4; acc_load in cycle 5; acc_en in cycles 6-8; y_load in cycle 9; busy falls in cycle 10.
- Back-to-back: sample_valid at cycles 0 and 4 -> tap_valid high continuously for cycles 1-8; y_load in cycles 9 and 13.
- Overrun: sample_valid at cycles 0 and 2 -> second strobe dropped, overrun=1 from cycle 3; only one y_load (cycle 9); overrun_clr pulse -> overrun=0.
- Reset mid-operation: reset_n low in cycle 6 after sample_valid at cycle 0 -> all outputs 0 and in_ready=1 immediately; no y_load afterwards.
- NUM_TAPS=1, PIPE_DELAY=1: sample_valid every cycle -> acc_load every cycle, acc_en never, y_load every cycle from cycle 3.
- With MAC_SEQ_COEFF_RAM_EN: write 39267 to addr 3 while idle, then run one sample -> coeff=39267 in cycle 4; a write at cycle 2 is ignored and sets cfg_err=1.
